// File: rtl/core_thread_sched.sv
// Per-core round scheduler: two context slots served on alternating ctx_num phases,
// emitting a registered per-round control stream and a tagged completion pulse.
module core_thread_sched #(
  parameter int unsigned N_ROUNDS  = 80,
  parameter int unsigned ROUND_MSB = $clog2(N_ROUNDS) - 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             ctx_num,
  input  logic             seq_num,
  output logic             rnd_en,
  output logic             rnd_ctx,
  output logic             rnd_seq,
  output logic [ROUND_MSB:0] rnd_num,
  output logic             rnd_first,
  output logic             rnd_last,
  output logic             done,
  output logic             done_ctx,
  output logic             done_seq,
  output logic             err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } slot_state_e;

  localparam logic [ROUND_MSB:0] LAST_RND = (ROUND_MSB + 1)'(N_ROUNDS - 1);

  slot_state_e          state_q [2];
  slot_state_e          state_d [2];
  logic [ROUND_MSB:0]   round_q [2];
  logic [ROUND_MSB:0]   round_d [2];
  logic                 seq_q   [2];
  logic                 seq_d   [2];

  logic                 issue;
  logic                 iss_seq;
  logic [ROUND_MSB:0]   iss_num;
  logic                 busy_start;

  logic                 rnd_en_q, rnd_ctx_q, rnd_seq_q, rnd_first_q, rnd_last_q;
  logic [ROUND_MSB:0]   rnd_num_q;
  logic                 done_q, done_ctx_q, done_seq_q, err_q;

  // Only the slot named by ctx_num is evaluated; the other slot holds its state.
  always_comb begin
    for (int unsigned c = 0; c < 2; c++) begin
      state_d[c] = state_q[c];
      round_d[c] = round_q[c];
      seq_d[c]   = seq_q[c];
    end
    issue      = 1'b0;
    iss_seq    = 1'b0;
    iss_num    = '0;
    busy_start = 1'b0;

    if (state_q[ctx_num] == S_IDLE) begin
      if (start) begin
        state_d[ctx_num] = S_RUN;
        round_d[ctx_num] = '0;
        seq_d[ctx_num]   = seq_num;
      end
    end else begin
      issue   = 1'b1;
      iss_seq = seq_q[ctx_num];
      iss_num = round_q[ctx_num];
      if (round_q[ctx_num] == LAST_RND) begin
        // A start on the final service re-arms the slot without passing through IDLE.
        if (start) begin
          round_d[ctx_num] = '0;
          seq_d[ctx_num]   = seq_num;
        end else begin
          state_d[ctx_num] = S_IDLE;
        end
      end else begin
        round_d[ctx_num] = round_q[ctx_num] + 1'b1;
        busy_start       = start;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned c = 0; c < 2; c++) begin
        state_q[c] <= S_IDLE;
        round_q[c] <= '0;
        seq_q[c]   <= 1'b0;
      end
      rnd_en_q    <= 1'b0;
      rnd_ctx_q   <= 1'b0;
      rnd_seq_q   <= 1'b0;
      rnd_num_q   <= '0;
      rnd_first_q <= 1'b0;
      rnd_last_q  <= 1'b0;
      done_q      <= 1'b0;
      done_ctx_q  <= 1'b0;
      done_seq_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < 2; c++) begin
        state_q[c] <= state_d[c];
        round_q[c] <= round_d[c];
        seq_q[c]   <= seq_d[c];
      end
      rnd_en_q <= issue;
      if (issue) begin
        rnd_ctx_q   <= ctx_num;
        rnd_seq_q   <= iss_seq;
        rnd_num_q   <= iss_num;
        rnd_first_q <= (iss_num == '0);
        rnd_last_q  <= (iss_num == LAST_RND);
      end
      done_q <= rnd_en_q & rnd_last_q;
      if (rnd_en_q && rnd_last_q) begin
        done_ctx_q <= rnd_ctx_q;
        done_seq_q <= rnd_seq_q;
      end
      err_q <= err_q | busy_start;
    end
  end

  assign rnd_en    = rnd_en_q;
  assign rnd_ctx   = rnd_ctx_q;
  assign rnd_seq   = rnd_seq_q;
  assign rnd_num   = rnd_num_q;
  assign rnd_first = rnd_first_q;
  assign rnd_last  = rnd_last_q;
  assign done      = done_q;
  assign done_ctx  = done_ctx_q;
  assign done_seq  = done_seq_q;
  assign err       = err_q;

endmodule

// File: tb/tb_core_thread_sched.sv
// Scoreboard bench for core_thread_sched: directed start sequence, expected strobes
// and completions queued at stimulus time and checked cycle by cycle.
module tb_core_thread_sched;

  localparam int N = 80;

  logic       CLK = 1'b0;
  logic       RST_N, start, ctx_num, seq_num;
  logic       rnd_en, rnd_ctx, rnd_seq, rnd_first, rnd_last;
  logic [6:0] rnd_num;
  logic       done, done_ctx, done_seq, err;

  core_thread_sched #(.N_ROUNDS(N)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .ctx_num(ctx_num), .seq_num(seq_num),
    .rnd_en(rnd_en), .rnd_ctx(rnd_ctx), .rnd_seq(rnd_seq), .rnd_num(rnd_num),
    .rnd_first(rnd_first), .rnd_last(rnd_last),
    .done(done), .done_ctx(done_ctx), .done_seq(done_seq), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct { int cyc; logic ctx; logic seq; int num; } strobe_t;
  typedef struct { int cyc; logic ctx; logic seq; } done_t;

  strobe_t sq[$];
  done_t   dq[$];
  int      cyc = 0;
  int      n_tests = 0;
  int      n_fail = 0;
  logic    err_exp = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    ctx_num = ~ctx_num;
  endtask

  task automatic wait_phase(input logic c);
    if (ctx_num !== c) tick();
  endtask

  task automatic push_run(input logic c, input logic s, input int t);
    strobe_t e;
    done_t   d;
    int      i;
    for (int r = 0; r < N; r++) begin
      e.cyc = t + 3 + 2 * r; e.ctx = c; e.seq = s; e.num = r;
      i = 0;
      while (i < sq.size() && sq[i].cyc < e.cyc) i++;
      sq.insert(i, e);
    end
    d.cyc = t + 3 + 2 * (N - 1) + 1; d.ctx = c; d.seq = s;
    i = 0;
    while (i < dq.size() && dq[i].cyc < d.cyc) i++;
    dq.insert(i, d);
  endtask

  task automatic do_start(input logic c, input logic s);
    wait_phase(c);
    seq_num = s;
    start   = 1'b1;
    push_run(c, s, cyc);
    tick();
    start   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rnd_en"},    rnd_en,    0);
    check({tag, "_rnd_ctx"},   rnd_ctx,   0);
    check({tag, "_rnd_seq"},   rnd_seq,   0);
    check({tag, "_rnd_num"},   rnd_num,   0);
    check({tag, "_rnd_first"}, rnd_first, 0);
    check({tag, "_rnd_last"},  rnd_last,  0);
    check({tag, "_done"},      done,      0);
    check({tag, "_done_ctx"},  done_ctx,  0);
    check({tag, "_done_seq"},  done_seq,  0);
    check({tag, "_err"},       err,       0);
  endtask

  always @(negedge CLK) begin
    strobe_t s;
    done_t   d;
    if (RST_N === 1'b1) begin
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        check("strobe_missed", cyc, sq[0].cyc);
        void'(sq.pop_front());
      end
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        s = sq.pop_front();
        check("rnd_en",    rnd_en,    1);
        check("rnd_ctx",   rnd_ctx,   32'(s.ctx));
        check("rnd_seq",   rnd_seq,   32'(s.seq));
        check("rnd_num",   rnd_num,   s.num);
        check("rnd_first", rnd_first, 32'(s.num == 0));
        check("rnd_last",  rnd_last,  32'(s.num == N - 1));
      end else begin
        check("rnd_en_idle", rnd_en, 0);
      end
      while (dq.size() > 0 && dq[0].cyc < cyc) begin
        check("done_missed", cyc, dq[0].cyc);
        void'(dq.pop_front());
      end
      if (dq.size() > 0 && dq[0].cyc == cyc) begin
        d = dq.pop_front();
        check("done",     done,     1);
        check("done_ctx", done_ctx, 32'(d.ctx));
        check("done_seq", done_seq, 32'(d.seq));
      end else begin
        check("done_idle", done, 0);
      end
      check("err", err, 32'(err_exp));
    end
  end

  initial begin
    int t;
    RST_N = 1'b0; start = 1'b0; seq_num = 1'b0; ctx_num = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    RST_N = 1'b1;
    repeat (2) tick();

    // single ctx0 run
    do_start(1'b0, 1'b1);
    repeat (170) tick();

    // interleaved contexts
    do_start(1'b0, 1'b0);
    do_start(1'b1, 1'b1);
    repeat (170) tick();

    // re-arm ctx1 on its last-round service cycle
    wait_phase(1'b1);
    t = cyc;
    do_start(1'b1, 1'b0);
    while (cyc < t + 160) tick();
    do_start(1'b1, 1'b1);
    repeat (170) tick();

    // start in ctx1 phase while ctx0 runs
    do_start(1'b0, 1'b1);
    repeat (20) tick();
    do_start(1'b1, 1'b0);
    repeat (170) tick();

    // busy restart of ctx0 at round 10
    wait_phase(1'b0);
    t = cyc;
    do_start(1'b0, 1'b0);
    while (cyc < t + 22) tick();
    seq_num = 1'b1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    err_exp = 1'b1;
    repeat (170) tick();

    // reset during round 40 of both slots
    wait_phase(1'b0);
    t = cyc;
    do_start(1'b0, 1'b1);
    do_start(1'b1, 1'b1);
    while (cyc < t + 82) tick();
    #2;
    RST_N = 1'b0;
    #1;
    check_all_zero("midreset");
    sq.delete();
    dq.delete();
    err_exp = 1'b0;
    repeat (2) tick();
    RST_N = 1'b1;
    repeat (4) tick();
    do_start(1'b0, 1'b1);
    repeat (170) tick();

    check("sq_drained", sq.size(), 0);
    check("dq_drained", dq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_thread_sched.md
# core_thread_sched

Per-core receiver for the start schedule issued by the unit-level core controller. It accepts `core_start` pulses for one core, its bit of `seq_num`, and the shared per-cycle `ctx_num` phase. It keeps two independent context slots (ctx0 and ctx1) and drives the SHA-512 core's per-round control stream, interleaved by context phase. When a slot's computation finishes, it emits a tagged completion pulse.

## Interface

Parameters:
- `N_ROUNDS`, 80: rounds per computation.
- `ROUND_MSB`, `` `MSB(N_ROUNDS-1) ``: MSB of the round index.

Clock, reset and scheduler inputs:
- `CLK`, input, 1: the single clock.
- `RST_N`, input, 1: reset, asynchronous assertion, active-low.
- `start`, input, 1: one-cycle start pulse for this core; this is the core's bit of the controller's `core_start`.
- `ctx_num`, input, 1: context phase from the controller; toggles every cycle.
- `seq_num`, input, 1: this core's sequence bit.

Round control outputs:
- `rnd_en`, output, 1: round-control strobe.
- `rnd_ctx`, output, 1: context of the current strobe.
- `rnd_seq`, output, 1: sequence tag latched at start.
- `rnd_num`, output, ROUND_MSB+1: round index.
- `rnd_first`, output, 1: asserted for round 0.
- `rnd_last`, output, 1: asserted for round N_ROUNDS-1.

Completion and error outputs:
- `done`, output, 1: completion pulse.
- `done_ctx`, output, 1: context of the completed computation.
- `done_seq`, output, 1: sequence tag of the completed computation.
- `err`, output, 1: sticky protocol error.

## Operation

**Definitions**
- A service cycle for slot c is any cycle in which `ctx_num == c`.
- Each slot holds `state`, which is IDLE or RUN, plus `round` and `seq`.

**Slot state machine** (per slot c, evaluated only on its service cycles)
- IDLE, `start`=1:
  - latch `seq` ← `seq_num`;
  - set `round` ← 0;
  - go to RUN.
  - No round is issued in this cycle.
- RUN:
  - issue round `round`;
  - if `round == N_ROUNDS-1`, go to IDLE; otherwise `round` ← `round`+1.
- RUN on its last round with `start`=1 in the same cycle:
  - issue the last round;
  - re-arm immediately (`seq` ← `seq_num`, `round` ← 0, stay RUN);
  - `err` is not set.
- RUN with `round != N_ROUNDS-1` and `start`=1:
  - `start` is ignored;
  - `err` ← 1 (sticky until reset);
  - the slot continues unaffected.
- `start` affects only the slot named by `ctx_num` in the same cycle. The other slot never reacts to it.

**Issuing a round**
- On the next cycle: `rnd_en`=1, `rnd_ctx`=c, `rnd_seq`=`seq`, `rnd_num`=`round`.
- `rnd_first` = (`round`==0); `rnd_last` = (`round`==N_ROUNDS-1).
- When no round is issued, `rnd_en`=0. The other `rnd_*` outputs hold their last values; only `rnd_en` qualifies them.

**Completion**
- The cycle after a `rnd_last` strobe: `done`=1 for one cycle, with `done_ctx`/`done_seq` copied from that strobe.
- `done` and `rnd_en` for the other slot may be high in the same cycle.

**Arithmetic**
- `round` is an unsigned counter ROUND_MSB+1 bits wide.
- It never exceeds N_ROUNDS-1; there is no wrap beyond the terminal compare.

## Timing

**Reset**
- `RST_N` low asynchronously forces both slots to IDLE with `round`=0 and `seq`=0.
- All outputs go to 0 (`rnd_*`, `done*`, `err`).
- Reset mid-computation discards both slots; no `done` is emitted.

**Latency**
- `start` in cycle t with `ctx_num`=c puts slot c in RUN.
- First strobe (`rnd_first`): cycle t+3, because the first service is t+2 and outputs are registered.
- Strobes then follow every 2 cycles; `rnd_last` appears at t+3+2·(N_ROUNDS-1) = t+161 for the default.
- `done` appears at t+162.

**Throughput and phase**
- At most one `rnd_en` per cycle.
- ctx0 strobes appear only in cycles following `ctx_num`=0.
- With both slots running, `rnd_en` is continuously high and `rnd_ctx` alternates.

**Back-to-back re-arm**
- `start` in the last-round service cycle gives a new `rnd_first` exactly 2 cycles after the preceding `rnd_last`.

## Test plan

- **Single ctx0 run:** reset, then `start`=1 with `ctx_num`=0 and `seq_num`=1 at t → exactly 80 `rnd_en` strobes at t+3, t+5, …, t+161, each with `rnd_ctx`=0 and `rnd_seq`=1; `rnd_num` counts 0..79; `rnd_first` only on the first strobe and `rnd_last` only on the last; `done`=1 at t+162 with `done_ctx`=0 and `done_seq`=1; `err`=0.
- **Interleaved contexts:** `start` with ctx 0 at t (seq 0), then `start` with ctx 1 at t+1 (seq 1) → `rnd_en` high every cycle from t+3 to t+162 with `rnd_ctx` alternating 0,1; `done` for ctx0 at t+162 and for ctx1 at t+163.
- **Busy restart:** a second ctx0 `start` arrives while ctx0 is at round 10 → `err`=1 and stays set; the round sequence continues 11..79 unchanged; a single `done` is emitted.
- **Re-arm on last round:** a ctx1 `start` coincides with the ctx1 last-round service cycle → `rnd_last`, then a new `rnd_first` for ctx1 2 cycles later; `done` for the first run is emitted; `err`=0.
- **Reset mid-operation:** `RST_N` is pulsed low during round 40 of both slots → all outputs are 0 immediately; no `done` follows; a fresh `start` afterwards behaves exactly as in the single ctx0 run.
- **Ignored phase:** `start` pulses in the ctx1 phase while ctx1 is idle and ctx0 is running → only ctx1 arms; the ctx0 stream is undisturbed.
